// File: rtl/cabac_ep_if.sv
// Bundle between the bypass-bin sequencer and its neighbours: the parser command/result
// ports, the bitstream byte feed and the arithmetic-decoder engine controls.
interface cabac_ep_if #(
    parameter int MAX_BINS = 16,
    parameter int CNT_W    = 5,
    parameter int TOT_W    = 32
);
    logic                flush;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CNT_W-1:0]    cmd_nbins;
    logic                byte_valid;
    logic                byte_ready;
    logic [7:0]          byte_data;
    logic                eng_step;
    logic [7:0]          eng_data;
    logic                eng_byte_req;
    logic                eng_bin;
    logic                res_valid;
    logic                res_ready;
    logic [MAX_BINS-1:0] res_bins;
    logic [CNT_W-1:0]    res_count;
    logic                res_clamped;
    logic                busy;
    logic [TOT_W-1:0]    bin_total;
    logic [1:0]          dbg_state;

    modport slave (
        input  flush, cmd_valid, cmd_nbins, byte_valid, byte_data,
               eng_byte_req, eng_bin, res_ready,
        output cmd_ready, byte_ready, eng_step, eng_data, res_valid,
               res_bins, res_count, res_clamped, busy, bin_total, dbg_state
    );

    modport master (
        output flush, cmd_valid, cmd_nbins, byte_valid, byte_data,
               eng_byte_req, eng_bin, res_ready,
        input  cmd_ready, byte_ready, eng_step, eng_data, res_valid,
               res_bins, res_count, res_clamped, busy, bin_total, dbg_state
    );
endinterface

// File: rtl/cabac_ep_sequencer.sv
// Steps the CABAC bypass decoding engine once per requested bin, feeding it bitstream
// bytes on demand and packing the decoded bins MSB-first into a single result.
module cabac_ep_sequencer #(
    parameter int MAX_BINS = 16,
    parameter int CNT_W    = 5,
    parameter int TOT_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    cabac_ep_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    res_count_q;
    logic [MAX_BINS-1:0] shift_q;
    logic                res_clamped_q;
    logic [TOT_W-1:0]    bin_total_q;

    logic                stepping;
    logic                step;
    logic                req_clamp;
    logic [CNT_W-1:0]    nbins_clamped;

    // Every handshake transfers exactly on a cycle where valid & ready are both high;
    // ready never looks at valid, and flush/reset suppress all transfers that cycle.
    assign stepping       = (state_q == RUN || state_q == STALL) && !bus.flush && !reset;
    assign bus.byte_ready = stepping & bus.eng_byte_req;
    assign step           = stepping & (~bus.eng_byte_req | bus.byte_valid);
    assign bus.eng_step   = step;
    assign bus.eng_data   = bus.byte_ready ? bus.byte_data : 8'h00;

    assign req_clamp     = bus.cmd_nbins > CNT_W'(MAX_BINS);
    assign nbins_clamped = req_clamp ? CNT_W'(MAX_BINS) : bus.cmd_nbins;

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.res_bins    = shift_q;
    assign bus.res_count   = res_count_q;
    assign bus.res_clamped = res_clamped_q;
    assign bus.bin_total   = bin_total_q;
    assign bus.dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            shift_q       <= '0;
            res_count_q   <= '0;
            res_clamped_q <= 1'b0;
            bin_total_q   <= '0;
        end else if (bus.flush) begin
            state_q       <= IDLE;
            remaining_q   <= '0;
            shift_q       <= '0;
            res_count_q   <= '0;
            res_clamped_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining_q   <= nbins_clamped;
                        res_count_q   <= nbins_clamped;
                        res_clamped_q <= req_clamp;
                        shift_q       <= '0;
                        state_q       <= (nbins_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN, STALL: begin
                    // A step taken from STALL is the byte arrival; it resumes RUN like any other.
                    if (step) begin
                        shift_q     <= {shift_q[MAX_BINS-2:0], bus.eng_bin};
                        remaining_q <= remaining_q - CNT_W'(1);
                        bin_total_q <= bin_total_q + TOT_W'(1);
                        state_q     <= (remaining_q == CNT_W'(1)) ? DONE : RUN;
                    end else begin
                        state_q <= STALL;
                    end
                end
                DONE: begin
                    if (bus.res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cabac_ep_sequencer.sv
// Bench for cabac_ep_sequencer: directed scenarios plus random traffic, all checked each
// cycle against a queue-based behavioural model of the command/bin/result flow.
module tb_cabac_ep_sequencer;
    localparam int MAX_BINS = 16;
    localparam int CNT_W    = 5;
    localparam int TOT_W    = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cabac_ep_if #(.MAX_BINS(MAX_BINS), .CNT_W(CNT_W), .TOT_W(TOT_W)) bus ();

    cabac_ep_sequencer #(.MAX_BINS(MAX_BINS), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- drive values ----------------
    logic             d_rst, d_fl, d_cv, d_bv, d_req, d_bin, d_rr;
    logic [CNT_W-1:0] d_nb;
    logic [7:0]       d_bd;

    // ---------------- observed values ----------------
    logic [31:0] o_step, o_br, o_rv, o_cr, o_busy, o_data, o_bins, o_cnt, o_clamp, o_total;

    // ---------------- behavioural model ----------------
    bit          m_known, m_idle, m_active, m_done, m_show, m_clamp;
    int          m_n;
    bit          m_bits[$];
    logic [31:0] m_total;
    logic [MAX_BINS+CNT_W:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [MAX_BINS-1:0] pack_bins();
        logic [31:0] v;
        v = 0;
        foreach (m_bits[i]) v = v * 2 + 32'(m_bits[i]);
        return MAX_BINS'(v);
    endfunction

    task automatic defaults();
        d_rst = 0; d_fl = 0; d_cv = 0; d_nb = '0; d_bv = 0; d_bd = 8'h00;
        d_req = 0; d_bin = 0; d_rr = 0;
    endtask

    // ---------------- driver + per-cycle compare + model advance ----------------
    task automatic cyc();
        bit          exp_step, exp_br;
        logic [31:0] got;
        @(negedge clk);
        reset            = d_rst;
        bus.flush        = d_fl;
        bus.cmd_valid    = d_cv;
        bus.cmd_nbins    = d_nb;
        bus.byte_valid   = d_bv;
        bus.byte_data    = d_bd;
        bus.eng_byte_req = d_req;
        bus.eng_bin      = d_bin;
        bus.res_ready    = d_rr;
        #1;
        o_step = 32'(bus.eng_step);  o_br   = 32'(bus.byte_ready); o_rv = 32'(bus.res_valid);
        o_cr   = 32'(bus.cmd_ready); o_busy = 32'(bus.busy);       o_data = 32'(bus.eng_data);
        o_bins = 32'(bus.res_bins);  o_cnt  = 32'(bus.res_count);  o_clamp = 32'(bus.res_clamped);
        o_total = 32'(bus.bin_total);
        if (m_known && !d_rst) begin
            exp_step = m_active && !d_fl && (!d_req || d_bv);
            exp_br   = m_active && !d_fl && d_req;
            check("cmd_ready", o_cr, 32'(m_idle));
            check("busy", o_busy, 32'(!m_idle));
            check("res_valid", o_rv, 32'(m_done));
            check("eng_step", o_step, 32'(exp_step));
            check("byte_ready", o_br, 32'(exp_br));
            check("eng_data", o_data, exp_br ? 32'(d_bd) : 32'h0);
            check("bin_total", o_total, m_total);
            if (m_done || m_show) begin
                check("res_bins", o_bins, 32'(pack_bins()));
                check("res_count", o_cnt, 32'(m_n));
                check("res_clamped", o_clamp, 32'(m_clamp));
            end
            if (m_done && d_rr && !d_fl) begin
                got = 32'({bus.res_clamped, bus.res_count, bus.res_bins});
                if (exp_q.size() == 0) check("sb_underflow", 32'(1), 32'(0));
                else check("sb_result", got, 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        if (d_rst) begin
            m_known = 1; m_idle = 1; m_active = 0; m_done = 0; m_show = 1;
            m_n = 0; m_clamp = 0; m_bits.delete(); m_total = 0; exp_q.delete();
        end else if (!m_known) begin
        end else if (d_fl) begin
            m_idle = 1; m_active = 0; m_done = 0; m_show = 1;
            m_n = 0; m_clamp = 0; m_bits.delete(); exp_q.delete();
        end else if (m_idle && d_cv) begin
            m_n = (int'(d_nb) > MAX_BINS) ? MAX_BINS : int'(d_nb);
            m_clamp = int'(d_nb) > MAX_BINS;
            m_bits.delete(); m_show = 0; m_idle = 0;
            if (m_n == 0) begin
                m_done = 1;
                exp_q.push_back({m_clamp, CNT_W'(m_n), pack_bins()});
            end else m_active = 1;
        end else if (m_active && (!d_req || d_bv)) begin
            m_bits.push_back(d_bin);
            m_total = m_total + 1;
            if (m_bits.size() == m_n) begin
                m_active = 0; m_done = 1;
                exp_q.push_back({m_clamp, CNT_W'(m_n), pack_bins()});
            end
        end else if (m_done && d_rr) begin
            m_done = 0; m_idle = 1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int steps, stalls, xfers;
        logic [31:0] t0;
        bit pat[4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        m_known = 0; m_total = 0;
        defaults();

        d_rst = 1; cyc(); cyc(); d_rst = 0;
        cyc();
        check("rst_res_valid", o_rv, 32'h0);
        check("rst_total", o_total, 32'h0);
        check("rst_cmd_ready", o_cr, 32'h1);
        check("rst_res_bins", o_bins, 32'h0);

        // 4 bins, no byte requests
        d_cv = 1; d_nb = 4; cyc(); defaults();
        steps = 0;
        for (int i = 0; i < 4; i++) begin d_bin = pat[i]; cyc(); steps += int'(o_step); end
        d_rr = 1; cyc(); defaults();
        check("t1_steps", 32'(steps), 32'd4);
        check("t1_valid_T5", o_rv, 32'h1);
        check("t1_bins", o_bins, 32'h000B);
        check("t1_count", o_cnt, 32'd4);

        // 3 bins with a 3-cycle byte stall on the 2nd step
        d_cv = 1; d_nb = 3; cyc(); defaults();
        d_bin = 1; cyc();
        stalls = 0; xfers = 0;
        d_req = 1; d_bv = 0; d_bin = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (o_step == 0 && o_br == 1) stalls++;
        end
        d_bv = 1; d_bd = 8'hA5; cyc();
        xfers += int'(o_br[0] & d_bv);
        check("t2_byte_step", o_step, 32'h1);
        check("t2_eng_data", o_data, 32'hA5);
        defaults(); d_bin = 1; cyc();
        d_rr = 1; cyc(); defaults();
        check("t2_stalls", 32'(stalls), 32'd3);
        check("t2_xfers", 32'(xfers), 32'd1);
        check("t2_valid_T7", o_rv, 32'h1);
        check("t2_bins", o_bins, 32'h0005);

        // clamped request
        d_cv = 1; d_nb = 20; cyc(); defaults();
        steps = 0; d_bin = 1;
        for (int i = 0; i < 16; i++) begin cyc(); steps += int'(o_step); end
        d_rr = 1; cyc(); defaults();
        check("t3_steps", 32'(steps), 32'd16);
        check("t3_bins", o_bins, 32'hFFFF);
        check("t3_count", o_cnt, 32'd16);
        check("t3_clamped", o_clamp, 32'h1);

        // zero bins
        d_cv = 1; d_nb = 0; cyc(); defaults();
        d_req = 1; d_bv = 1; d_rr = 1; cyc(); defaults();
        check("t4_valid", o_rv, 32'h1);
        check("t4_bins", o_bins, 32'h0);
        check("t4_step", o_step, 32'h0);
        check("t4_byte_ready", o_br, 32'h0);

        // flush during STALL
        cyc(); t0 = o_total;
        d_cv = 1; d_nb = 3; cyc(); defaults();
        d_bin = 1; cyc();
        d_req = 1; cyc();
        d_bv = 1; d_fl = 1; d_bd = 8'h3C; cyc();
        check("t5_flush_step", o_step, 32'h0);
        check("t5_flush_byte_ready", o_br, 32'h0);
        defaults(); d_cv = 1; d_nb = 2; cyc(); defaults();
        check("t5_idle_after_flush", o_busy, 32'h0);
        check("t5_total_kept", o_total, t0 + 1);
        d_bin = 1; cyc(); d_bin = 0; cyc();
        d_rr = 1; cyc(); defaults();
        check("t5_bins", o_bins, 32'h0002);
        check("t5_total", o_total, t0 + 3);

        // held result, commands ignored
        d_cv = 1; d_nb = 1; cyc(); defaults();
        d_bin = 1; cyc();
        d_cv = 1; d_nb = 7;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t6_hold_bins", o_bins, 32'h0001);
            check("t6_hold_cmd_ready", o_cr, 32'h0);
        end
        d_rr = 1; cyc(); d_rr = 0;
        d_nb = 1; cyc();
        check("t6_accept", o_cr, 32'h1);
        defaults(); d_bin = 0; cyc();
        d_rr = 1; cyc(); defaults();
        check("t6_new_valid", o_rv, 32'h1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            d_rst = ($urandom_range(0, 599) == 0);
            d_fl  = ($urandom_range(0, 59) == 0);
            d_cv  = $urandom_range(0, 1);
            d_nb  = CNT_W'($urandom_range(0, 20));
            d_bv  = ($urandom_range(0, 2) != 0);
            d_bd  = 8'($urandom);
            d_req = ($urandom_range(0, 2) == 0);
            d_bin = $urandom_range(0, 1);
            d_rr  = $urandom_range(0, 1);
            cyc();
        end
        defaults(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
